paint_source_arbiter: RTL and testbench
=======================================

PAINT_SOURCE_ARBITER -- requirements
Module: paint_source_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of paint source channels (2..8).
REQ-002 SHALL have parameter SLOT_CYCLES, default 512, clock cycles per channel time slot (>=2).
REQ-003 SHALL have parameter H_RES, default 320, screen width in pixels.
REQ-004 SHALL have parameter V_RES, default 240, screen height in pixels.
REQ-005 SHALL have parameter SKIP_IDLE, default 1; 1 = skip channels with no plot request at a slot boundary.
REQ-006 SHALL have parameters X_W 9, Y_W 8 and C_W 3, the widths of the X, Y and colour fields.
REQ-007 SHALL have port CLOCK_50, in, 1, the only clock; all logic is rising-edge.
REQ-008 SHALL have port rstn, in, 1, asynchronous active-low reset.
REQ-009 SHALL have port game_display_en, in, 1; 1 enables slot arbitration.
REQ-010 SHALL have port background_color, in, C_W, colour used during a screen clear.
REQ-011 SHALL have port clear_req, in, 1, a single-cycle request to clear the full screen.
REQ-012 SHALL have port ch_color, in, N_CH*C_W, per-channel colour; channel i occupies bits [i*C_W +: C_W].
REQ-013 SHALL have ports ch_x, in, N_CH*X_W, and ch_y, in, N_CH*Y_W, per-channel coordinates, packed the same way as ch_color.
REQ-014 SHALL have port ch_plot, in, N_CH, per-channel plot enable.
REQ-015 SHALL have outputs VGA_X (X_W), VGA_Y (Y_W), VGA_COLOR (C_W) and plot_enable (1), all registered, driving the VGA adapter.
REQ-016 SHALL have outputs active_ch, out, clog2(N_CH), the channel owning the current slot; slot_start, out, 1, a pulse on the first cycle of a slot; clear_busy, out, 1, high while clearing.

Function
REQ-017 SHALL implement the states IDLE, CLEAR and SLOT.
REQ-018 In IDLE: plot_enable = 0 and VGA_X/VGA_Y/VGA_COLOR hold their values.
REQ-019 IDLE exits: clear_req -> CLEAR; otherwise game_display_en = 1 -> SLOT, starting at channel 0.
REQ-020 In CLEAR: the block SHALL sweep x 0..H_RES-1 (inner loop) and y 0..V_RES-1 (outer loop), one pixel per cycle.
REQ-021 During CLEAR: plot_enable = 1, VGA_COLOR = background_color and clear_busy = 1.
REQ-022 A clear SHALL last exactly H_RES*V_RES cycles.
REQ-023 After the last pixel, CLEAR SHALL go to SLOT (channel 0) if game_display_en = 1, else to IDLE.
REQ-024 clear_req and game_display_en SHALL be ignored during CLEAR.
REQ-025 In SLOT: on each cycle, VGA_X/VGA_Y/VGA_COLOR/plot_enable SHALL register the fields of channel active_ch sampled that cycle (one-cycle latency).
REQ-026 The slot cycle counter SHALL count 0..SLOT_CYCLES-1; slot_start = 1 when the count is 0.
REQ-027 At count SLOT_CYCLES-1, the next channel SHALL be chosen round-robin from active_ch+1 (mod N_CH).
REQ-028 With SKIP_IDLE = 1, the first channel in round-robin order with ch_plot = 1 at the boundary cycle SHALL win.
REQ-029 If no channel requests at the boundary, active_ch+1 mod N_CH SHALL win.
REQ-030 With SKIP_IDLE = 0, active_ch+1 mod N_CH SHALL always win.
REQ-031 A clear_req arriving during SLOT SHALL be latched and SHALL take effect at the slot boundary (CLEAR replaces the next slot).
REQ-032 After a latched clear, the block SHALL resume at active_ch+1; the latch SHALL clear on entry to CLEAR; duplicate requests SHALL merge.
REQ-033 If game_display_en = 0 in SLOT, the next state SHALL be IDLE, and plot_enable SHALL be 0 from the following cycle.
REQ-034 The counter and active_ch SHALL reset to 0 on entry to IDLE.

Reset
REQ-035 While rstn = 0: state = IDLE; all outputs, counters, active_ch and the clear latch = 0.
REQ-036 Reset asserted mid-CLEAR or mid-SLOT SHALL abort immediately; there is no resume.
REQ-037 The first SLOT after reset release SHALL start at channel 0 with slot_start = 1.

Verification
REQ-038 (N_CH=4, SLOT_CYCLES=8) en=1, ch_plot=4'b1111 -> active_ch 0,1,2,3,0 every 8 cycles; VGA_X = ch_x of the owner, 1 cycle late.
REQ-039 SKIP_IDLE=1, ch_plot=4'b0101 -> active_ch alternates 0,2,0; SKIP_IDLE=0, same stimulus -> 0,1,2,3 with plot_enable low in slots 1 and 3.
REQ-040 (H_RES=4, V_RES=2) clear_req in IDLE, background_color=3'b110 -> 8 cycles of plot_enable=1, (X,Y) = (0,0),(1,0)..(3,1), clear_busy high, then SLOT ch0.
REQ-041 clear_req pulsed twice mid-slot 1 -> one clear after slot 1 ends, then slot 2.
REQ-042 rstn low mid-CLEAR at pixel (2,1), then released -> outputs 0, state IDLE, no residual clear.
REQ-043 en dropped at count 3 of slot 2 -> plot_enable 0 the next cycle; re-enable -> slot restarts at ch0, count 0.

Source files
------------

// File: rtl/paint_source_arbiter.sv
// Time-slot arbiter multiplexing N_CH paint sources onto a single VGA plot port,
// with a full-screen clear sweep that can preempt the next slot.
module paint_source_arbiter #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SLOT_CYCLES = 512,
  parameter int unsigned H_RES       = 320,
  parameter int unsigned V_RES       = 240,
  parameter int unsigned SKIP_IDLE   = 1,
  parameter int unsigned X_W         = 9,
  parameter int unsigned Y_W         = 8,
  parameter int unsigned C_W         = 3
) (
  input  logic                      CLOCK_50,
  input  logic                      rstn,
  input  logic                      game_display_en,
  input  logic [C_W-1:0]            background_color,
  input  logic                      clear_req,
  input  logic [N_CH*C_W-1:0]       ch_color,
  input  logic [N_CH*X_W-1:0]       ch_x,
  input  logic [N_CH*Y_W-1:0]       ch_y,
  input  logic [N_CH-1:0]           ch_plot,
  output logic [X_W-1:0]            VGA_X,
  output logic [Y_W-1:0]            VGA_Y,
  output logic [C_W-1:0]            VGA_COLOR,
  output logic                      plot_enable,
  output logic [$clog2(N_CH)-1:0]   active_ch,
  output logic                      slot_start,
  output logic                      clear_busy
);

  localparam int unsigned CH_W  = $clog2(N_CH);
  localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SLOT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             clr_pend_q, clr_pend_d;
  logic [X_W-1:0]   cx_q, cx_d;
  logic [Y_W-1:0]   cy_q, cy_d;
  logic [X_W-1:0]   vx_q, vx_d;
  logic [Y_W-1:0]   vy_q, vy_d;
  logic [C_W-1:0]   vc_q, vc_d;
  logic             plot_q, plot_d;
  logic             sstart_q, sstart_d;
  logic             busy_q, busy_d;

  logic [X_W-1:0]   x_arr [N_CH];
  logic [Y_W-1:0]   y_arr [N_CH];
  logic [C_W-1:0]   c_arr [N_CH];
  logic [CH_W-1:0]  nxt_plain;
  logic [CH_W-1:0]  rr_pick;

  // Unpack the per-channel buses so the owner can be selected by index.
  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign x_arr[g] = ch_x[g*X_W +: X_W];
    assign y_arr[g] = ch_y[g*Y_W +: Y_W];
    assign c_arr[g] = ch_color[g*C_W +: C_W];
  end

  // Round-robin successor; scanning downward lets the nearest requester win.
  always_comb begin
    int unsigned idx;
    nxt_plain = (ch_q == CH_W'(N_CH-1)) ? '0 : ch_q + CH_W'(1);
    rr_pick   = nxt_plain;
    idx       = 0;
    if (SKIP_IDLE != 0) begin
      for (int i = int'(N_CH); i >= 1; i--) begin
        idx = (32'(ch_q) + 32'(i)) % N_CH;
        if (ch_plot[CH_W'(idx)]) rr_pick = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    clr_pend_d = clr_pend_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    vc_d       = vc_q;
    plot_d     = 1'b0;
    sstart_d   = 1'b0;
    busy_d     = (state_q == S_CLEAR);

    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          cx_d    = '0;
          cy_d    = '0;
        end else if (game_display_en) begin
          state_d  = S_SLOT;
          cnt_d    = '0;
          ch_d     = '0;
          sstart_d = 1'b1;
        end
      end

      S_CLEAR: begin
        plot_d = 1'b1;
        vx_d   = cx_q;
        vy_d   = cy_q;
        vc_d   = background_color;
        if (cx_q == X_W'(H_RES-1)) begin
          cx_d = '0;
          if (cy_q == Y_W'(V_RES-1)) begin
            cy_d  = '0;
            cnt_d = '0;
            if (game_display_en) begin
              state_d  = S_SLOT;
              sstart_d = 1'b1;
            end else begin
              state_d = S_IDLE;
              ch_d    = '0;
            end
          end else begin
            cy_d = cy_q + Y_W'(1);
          end
        end else begin
          cx_d = cx_q + X_W'(1);
        end
      end

      S_SLOT: begin
        clr_pend_d = clr_pend_q | clear_req;
        if (!game_display_en) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          ch_d       = '0;
          clr_pend_d = 1'b0;
        end else begin
          vx_d   = x_arr[ch_q];
          vy_d   = y_arr[ch_q];
          vc_d   = c_arr[ch_q];
          plot_d = ch_plot[ch_q];
          if (cnt_q == CNT_W'(SLOT_CYCLES-1)) begin
            cnt_d = '0;
            // A pending clear takes the next slot; play resumes after this channel.
            if (clr_pend_q || clear_req) begin
              state_d    = S_CLEAR;
              cx_d       = '0;
              cy_d       = '0;
              clr_pend_d = 1'b0;
              ch_d       = nxt_plain;
            end else begin
              ch_d     = rr_pick;
              sstart_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      clr_pend_q <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      vx_q       <= '0;
      vy_q       <= '0;
      vc_q       <= '0;
      plot_q     <= 1'b0;
      sstart_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      clr_pend_q <= clr_pend_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      vc_q       <= vc_d;
      plot_q     <= plot_d;
      sstart_q   <= sstart_d;
      busy_q     <= busy_d;
    end
  end

  assign VGA_X       = vx_q;
  assign VGA_Y       = vy_q;
  assign VGA_COLOR   = vc_q;
  assign plot_enable = plot_q;
  assign active_ch   = ch_q;
  assign slot_start  = sstart_q;
  assign clear_busy  = busy_q;

endmodule

// File: tb/tb_paint_source_arbiter.sv
// Bench for paint_source_arbiter: two instances (skip / no-skip) on shared stimulus,
// round-robin table scenarios plus clear, reset and enable-drop sequences.
module tb_paint_source_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned SC = 8;
  localparam int unsigned XW = 9;
  localparam int unsigned YW = 8;
  localparam int unsigned CW = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic            en;
  logic [CW-1:0]   bg;
  logic            clr;
  logic [N*CW-1:0] ch_color;
  logic [N*XW-1:0] ch_x;
  logic [N*YW-1:0] ch_y;
  logic [N-1:0]    ch_plot;

  logic [XW-1:0] vx_s, vx_n;
  logic [YW-1:0] vy_s, vy_n;
  logic [CW-1:0] vc_s, vc_n;
  logic          pe_s, pe_n, ss_s, ss_n, cb_s, cb_n;
  logic [1:0]    ac_s, ac_n;

  always #5 clk = ~clk;

  paint_source_arbiter #(.N_CH(N), .SLOT_CYCLES(SC), .H_RES(4), .V_RES(2), .SKIP_IDLE(1),
                         .X_W(XW), .Y_W(YW), .C_W(CW)) dut (
    .CLOCK_50(clk), .rstn(rstn), .game_display_en(en), .background_color(bg),
    .clear_req(clr), .ch_color(ch_color), .ch_x(ch_x), .ch_y(ch_y), .ch_plot(ch_plot),
    .VGA_X(vx_s), .VGA_Y(vy_s), .VGA_COLOR(vc_s), .plot_enable(pe_s),
    .active_ch(ac_s), .slot_start(ss_s), .clear_busy(cb_s));

  paint_source_arbiter #(.N_CH(N), .SLOT_CYCLES(SC), .H_RES(4), .V_RES(2), .SKIP_IDLE(0),
                         .X_W(XW), .Y_W(YW), .C_W(CW)) dut_ns (
    .CLOCK_50(clk), .rstn(rstn), .game_display_en(en), .background_color(bg),
    .clear_req(clr), .ch_color(ch_color), .ch_x(ch_x), .ch_y(ch_y), .ch_plot(ch_plot),
    .VGA_X(vx_n), .VGA_Y(vy_n), .VGA_COLOR(vc_n), .plot_enable(pe_n),
    .active_ch(ac_n), .slot_start(ss_n), .clear_busy(cb_n));

  typedef struct {
    logic [3:0] plot;
    int         own_s [5];
    int         own_n [5];
  } vec_t;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
    logic          p;
  } exp_t;

  vec_t tbl [5];
  exp_t q_s [$];
  exp_t q_n [$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [XW-1:0] fx(input int i); return XW'(100 + i*7); endfunction
  function automatic logic [YW-1:0] fy(input int i); return YW'(50 + i*3);  endfunction
  function automatic logic [CW-1:0] fc(input int i); return CW'(i + 1);     endfunction

  function automatic exp_t mk(input int o, input logic [3:0] pl);
    exp_t e;
    e.x = fx(o);
    e.y = fy(o);
    e.c = fc(o);
    e.p = pl[2'(o)];
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input exp_t e, input logic [XW-1:0] x,
                         input logic [YW-1:0] y, input logic [CW-1:0] c, input logic p);
    chk({nm, "_x"}, 32'(x), 32'(e.x));
    chk({nm, "_y"}, 32'(y), 32'(e.y));
    chk({nm, "_c"}, 32'(c), 32'(e.c));
    chk({nm, "_p"}, 32'(p), 32'(e.p));
  endtask

  initial begin
    exp_t es, en_e;
    int   busy_cnt;

    tbl[0].plot = 4'b1111; tbl[0].own_s = '{0,1,2,3,0}; tbl[0].own_n = '{0,1,2,3,0};
    tbl[1].plot = 4'b0101; tbl[1].own_s = '{0,2,0,2,0}; tbl[1].own_n = '{0,1,2,3,0};
    tbl[2].plot = 4'b0000; tbl[2].own_s = '{0,1,2,3,0}; tbl[2].own_n = '{0,1,2,3,0};
    tbl[3].plot = 4'b1000; tbl[3].own_s = '{0,3,3,3,3}; tbl[3].own_n = '{0,1,2,3,0};
    tbl[4].plot = 4'b0110; tbl[4].own_s = '{0,1,2,1,2}; tbl[4].own_n = '{0,1,2,3,0};

    rstn = 1'b0; en = 1'b0; bg = '0; clr = 1'b0; ch_plot = '0;
    for (int i = 0; i < int'(N); i++) begin
      ch_x[i*XW +: XW]     = fx(i);
      ch_y[i*YW +: YW]     = fy(i);
      ch_color[i*CW +: CW] = fc(i);
    end
    repeat (3) step();
    chk("rst_x", 32'(vx_s), 32'(0));
    chk("rst_y", 32'(vy_s), 32'(0));
    chk("rst_c", 32'(vc_s), 32'(0));
    chk("rst_p", 32'(pe_s), 32'(0));
    chk("rst_ac", 32'(ac_s), 32'(0));
    chk("rst_ss", 32'(ss_s), 32'(0));
    chk("rst_cb", 32'(cb_s), 32'(0));
    rstn = 1'b1;
    step();

    // Round-robin scenarios: owner per slot from the table, outputs one cycle late.
    for (int t = 0; t < 5; t++) begin
      en = 1'b0;
      repeat (2) step();
      ch_plot = tbl[t].plot;
      en = 1'b1;
      for (int k = 0; k < 40; k++) begin
        int oa, ob;
        step();
        oa = tbl[t].own_s[k/8];
        ob = tbl[t].own_n[k/8];
        chk("act_s", 32'(ac_s), 32'(oa));
        chk("act_n", 32'(ac_n), 32'(ob));
        chk("sst_s", 32'(ss_s), 32'(k % 8 == 0));
        chk("sst_n", 32'(ss_n), 32'(k % 8 == 0));
        if (k > 0) begin
          es   = q_s.pop_front();
          en_e = q_n.pop_front();
          chk_out("out_s", es, vx_s, vy_s, vc_s, pe_s);
          chk_out("out_n", en_e, vx_n, vy_n, vc_n, pe_n);
        end
        if (k < 39) begin
          q_s.push_back(mk(oa, tbl[t].plot));
          q_n.push_back(mk(ob, tbl[t].plot));
        end
      end
      en = 1'b0;
      step();
      chk("drop_p_s", 32'(pe_s), 32'(0));
      chk("drop_p_n", 32'(pe_n), 32'(0));
    end

    // Clear from IDLE: 8 pixels in raster order, a mid-clear request is ignored.
    repeat (2) step();
    ch_plot = 4'b1111;
    bg = 3'b110; clr = 1'b1; en = 1'b1;
    step();
    clr = 1'b0;
    chk("clr0_cb", 32'(cb_s), 32'(0));
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("clr_p", 32'(pe_s), 32'(1));
      chk("clr_x", 32'(vx_s), 32'((i-1) % 4));
      chk("clr_y", 32'(vy_s), 32'((i-1) / 4));
      chk("clr_c", 32'(vc_s), 32'(3'b110));
      chk("clr_cb", 32'(cb_s), 32'(1));
      clr = (i == 4);
    end
    chk("clr_end_ac", 32'(ac_s), 32'(0));
    chk("clr_end_ss", 32'(ss_s), 32'(1));
    step();
    chk("post_clr_cb", 32'(cb_s), 32'(0));
    chk("post_clr_x", 32'(vx_s), 32'(fx(0)));
    chk("post_clr_p", 32'(pe_s), 32'(1));

    // Two clear requests in slot 1 merge into one clear, then slot 2 and slot 3.
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k <= 32; k++) begin
      step();
      busy_cnt += int'(cb_s);
      clr = (k == 10) || (k == 12);
      if (k == 16) begin
        chk("mclr16_ac", 32'(ac_s), 32'(2));
        chk("mclr16_ss", 32'(ss_s), 32'(0));
      end
      if (k == 24) begin
        chk("mclr24_ac", 32'(ac_s), 32'(2));
        chk("mclr24_ss", 32'(ss_s), 32'(1));
      end
      if (k == 32) begin
        chk("mclr32_ac", 32'(ac_s), 32'(3));
        chk("mclr32_ss", 32'(ss_s), 32'(1));
      end
    end
    clr = 1'b0;
    chk("mclr_busy_cycles", 32'(busy_cnt), 32'(8));

    // Reset asserted at pixel (2,1) of a clear aborts everything.
    en = 1'b0;
    repeat (2) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (6) step();
    chk("pre_rst_cb", 32'(cb_s), 32'(1));
    rstn = 1'b0;
    #1;
    chk("mrst_x", 32'(vx_s), 32'(0));
    chk("mrst_y", 32'(vy_s), 32'(0));
    chk("mrst_c", 32'(vc_s), 32'(0));
    chk("mrst_p", 32'(pe_s), 32'(0));
    chk("mrst_cb", 32'(cb_s), 32'(0));
    repeat (2) step();
    rstn = 1'b1;
    repeat (3) step();
    chk("arst_cb", 32'(cb_s), 32'(0));
    chk("arst_p", 32'(pe_s), 32'(0));
    en = 1'b1;
    step();
    chk("arst_ac", 32'(ac_s), 32'(0));
    chk("arst_ss", 32'(ss_s), 32'(1));
    step();
    chk("arst_ss2", 32'(ss_s), 32'(0));

    // Enable dropped at count 3 of slot 2, then re-enabled.
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    for (int k = 0; k <= 19; k++) step();
    chk("edrop_ac", 32'(ac_s), 32'(2));
    chk("edrop_p1", 32'(pe_s), 32'(1));
    en = 1'b0;
    step();
    chk("edrop_p0", 32'(pe_s), 32'(0));
    chk("edrop_ac0", 32'(ac_s), 32'(0));
    en = 1'b1;
    step();
    chk("reen_ac", 32'(ac_s), 32'(0));
    chk("reen_ss", 32'(ss_s), 32'(1));
    step();
    chk("reen_ss2", 32'(ss_s), 32'(0));
    chk("reen_x", 32'(vx_s), 32'(fx(0)));
    chk("reen_p", 32'(pe_s), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
